reorder_buffer: RTL

- Circular reorder buffer sitting directly downstream of the CDB.
- Allocates entries in program order for the dispatcher and absorbs RS/LSB result broadcasts by RoB index.
- Retires at most one instruction per cycle in order: register writeback, store commit release, branch misprediction flush, program exit.
- Answers dispatcher operand queries so renamed sources can be resolved from completed-but-uncommitted entries.

---
 rtl/reorder_buffer.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer downstream of the CDB.
// Allocates entries in program order, absorbs RS/LSB result broadcasts by
// index, retires at most one entry per cycle (register write, store release,
// misprediction flush, program exit) and answers dispatcher operand queries.
//
// Optional build macro: ROB_CDB_BYPASS_EN
//   defined   -> operand query also sees same-cycle CDB broadcasts (RS first)
//   undefined -> a broadcast becomes visible to the query one cycle later
//
// Handshake summary: allocation is a one-sided request. An entry is taken
// on a clock edge where DPRoB_en is high, RoBDP_full is low (pre-edge value),
// no flush is being signalled and the program has not halted; otherwise the
// request is silently dropped and the dispatcher must re-present it.
// CDB broadcasts are fire-and-forget and are absorbed only by busy entries.
// rdy_in low freezes every register and forces the pulse outputs low.
module reorder_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int RoB_WIDTH  = 3,
  parameter int RoB_SIZE   = 1 << RoB_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,

  // dispatcher allocation
  input  logic                  DPRoB_en,
  input  logic [1:0]            DPRoB_type,
  input  logic [REG_WIDTH-1:0]  DPRoB_rd,
  input  logic [ADDR_WIDTH-1:0] DPRoB_pred_pc,
  output logic                  RoBDP_full,
  output logic [RoB_WIDTH-1:0]  RoBDP_tail,

  // dispatcher operand query
  input  logic [RoB_WIDTH-1:0]  DPRoB_Qj,
  output logic                  RoBDP_Qj_ready,
  output logic [31:0]           RoBDP_Vj,

  // CDB result broadcasts
  input  logic                  CDBRoB_RS_en,
  input  logic [RoB_WIDTH-1:0]  CDBRoB_RS_RoB_index,
  input  logic [31:0]           CDBRoB_RS_value,
  input  logic [ADDR_WIDTH-1:0] CDBRoB_RS_next_pc,
  input  logic                  CDBRoB_LSB_en,
  input  logic [RoB_WIDTH-1:0]  CDBRoB_LSB_RoB_index,
  input  logic [31:0]           CDBRoB_LSB_value,

  // commit side
  output logic                  RoBRF_en,
  output logic [REG_WIDTH-1:0]  RoBRF_rd,
  output logic [31:0]           RoBRF_value,
  output logic [RoB_WIDTH-1:0]  RoBRF_RoB_index,
  output logic                  RoBLSB_commit_en,
  output logic [RoB_WIDTH-1:0]  RoBLSB_commit_index,
  output logic                  RoB_flush_en,
  output logic [ADDR_WIDTH-1:0] RoBIF_new_pc,
  output logic                  RoB_halt
);

  localparam logic [1:0] T_REG    = 2'b00;
  localparam logic [1:0] T_STORE  = 2'b01;
  localparam logic [1:0] T_BRANCH = 2'b10;
  localparam logic [1:0] T_EXIT   = 2'b11;

  localparam logic [RoB_WIDTH:0] FULL_COUNT = (RoB_WIDTH+1)'(RoB_SIZE);

  // entry storage
  logic [RoB_SIZE-1:0]   busy_q, busy_d;
  logic [RoB_SIZE-1:0]   ready_q, ready_d;
  logic [1:0]            type_q    [RoB_SIZE];
  logic [1:0]            type_d    [RoB_SIZE];
  logic [REG_WIDTH-1:0]  rd_q      [RoB_SIZE];
  logic [REG_WIDTH-1:0]  rd_d      [RoB_SIZE];
  logic [31:0]           value_q   [RoB_SIZE];
  logic [31:0]           value_d   [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] pred_pc_q [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] pred_pc_d [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] next_pc_q [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] next_pc_d [RoB_SIZE];

  // queue pointers and program state
  logic [RoB_WIDTH-1:0]  head_q, head_d;
  logic [RoB_WIDTH-1:0]  tail_q, tail_d;
  logic [RoB_WIDTH:0]    count_q, count_d;
  logic                  halt_q, halt_d;

  // registered commit outputs
  logic                  rf_en_q, rf_en_d;
  logic [REG_WIDTH-1:0]  rf_rd_q, rf_rd_d;
  logic [31:0]           rf_value_q, rf_value_d;
  logic [RoB_WIDTH-1:0]  rf_idx_q, rf_idx_d;
  logic                  lsb_en_q, lsb_en_d;
  logic [RoB_WIDTH-1:0]  lsb_idx_q, lsb_idx_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] new_pc_q, new_pc_d;

  logic                  full;
  logic                  do_alloc;
  logic                  do_commit;

  // Allocation/commit qualifiers; nothing moves during a flush cycle or after exit
  always_comb begin
    full      = (count_q == FULL_COUNT);
    do_alloc  = DPRoB_en && !full && !halt_q && !flush_q;
    do_commit = busy_q[head_q] && ready_q[head_q] && !halt_q && !flush_q;
  end

  // Next-state for entries, pointers and registered commit outputs
  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    type_d     = type_q;
    rd_d       = rd_q;
    value_d    = value_q;
    pred_pc_d  = pred_pc_q;
    next_pc_d  = next_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    halt_d     = halt_q;
    rf_en_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_value_d = rf_value_q;
    rf_idx_d   = rf_idx_q;
    lsb_en_d   = 1'b0;
    lsb_idx_d  = lsb_idx_q;
    flush_d    = 1'b0;
    new_pc_d   = new_pc_q;

    if (flush_q) begin
      // Misprediction recovery: drop every in-flight entry and restart at 0.
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // LSB first so that an RS write to the same index overrides it.
      if (CDBRoB_LSB_en && busy_q[CDBRoB_LSB_RoB_index]) begin
        ready_d[CDBRoB_LSB_RoB_index] = 1'b1;
        value_d[CDBRoB_LSB_RoB_index] = CDBRoB_LSB_value;
      end
      if (CDBRoB_RS_en && busy_q[CDBRoB_RS_RoB_index]) begin
        ready_d[CDBRoB_RS_RoB_index]   = 1'b1;
        value_d[CDBRoB_RS_RoB_index]   = CDBRoB_RS_value;
        next_pc_d[CDBRoB_RS_RoB_index] = CDBRoB_RS_next_pc;
      end

      if (do_commit) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        case (type_q[head_q])
          T_REG: begin
            rf_en_d    = 1'b1;
            rf_rd_d    = rd_q[head_q];
            rf_value_d = value_q[head_q];
            rf_idx_d   = head_q;
          end
          T_STORE: begin
            lsb_en_d  = 1'b1;
            lsb_idx_d = head_q;
          end
          T_BRANCH: begin
            if (rd_q[head_q] != '0) begin
              rf_en_d    = 1'b1;
              rf_rd_d    = rd_q[head_q];
              rf_value_d = value_q[head_q];
              rf_idx_d   = head_q;
            end
            if (next_pc_q[head_q] != pred_pc_q[head_q]) begin
              flush_d  = 1'b1;
              new_pc_d = next_pc_q[head_q];
            end
          end
          default: begin
            halt_d = 1'b1;
          end
        endcase
      end

      // Tail slot is never busy while not full, so it cannot collide with
      // a CDB write or the commit above.
      if (do_alloc) begin
        busy_d[tail_q]    = 1'b1;
        ready_d[tail_q]   = (DPRoB_type == T_EXIT);
        type_d[tail_q]    = DPRoB_type;
        rd_d[tail_q]      = DPRoB_rd;
        pred_pc_d[tail_q] = DPRoB_pred_pc;
        value_d[tail_q]   = '0;
        next_pc_d[tail_q] = '0;
        tail_d            = tail_q + 1'b1;
      end

      count_d = count_q + (RoB_WIDTH+1)'(do_alloc) - (RoB_WIDTH+1)'(do_commit);
    end
  end

  // State registers: synchronous active-low reset, frozen while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q     <= '0;
      ready_q    <= '0;
      for (int i = 0; i < RoB_SIZE; i++) begin
        type_q[i]    <= '0;
        rd_q[i]      <= '0;
        value_q[i]   <= '0;
        pred_pc_q[i] <= '0;
        next_pc_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      halt_q     <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_value_q <= '0;
      rf_idx_q   <= '0;
      lsb_en_q   <= 1'b0;
      lsb_idx_q  <= '0;
      flush_q    <= 1'b0;
      new_pc_q   <= '0;
    end else if (rdy_in) begin
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      type_q     <= type_d;
      rd_q       <= rd_d;
      value_q    <= value_d;
      pred_pc_q  <= pred_pc_d;
      next_pc_q  <= next_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      halt_q     <= halt_d;
      rf_en_q    <= rf_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_value_q <= rf_value_d;
      rf_idx_q   <= rf_idx_d;
      lsb_en_q   <= lsb_en_d;
      lsb_idx_q  <= lsb_idx_d;
      flush_q    <= flush_d;
      new_pc_q   <= new_pc_d;
    end
  end

  // Operand query, optionally forwarding same-cycle broadcasts
  always_comb begin
    RoBDP_Qj_ready = busy_q[DPRoB_Qj] && ready_q[DPRoB_Qj];
    RoBDP_Vj       = value_q[DPRoB_Qj];
`ifdef ROB_CDB_BYPASS_EN
    if (!flush_q && busy_q[DPRoB_Qj]) begin
      if (CDBRoB_RS_en && (CDBRoB_RS_RoB_index == DPRoB_Qj)) begin
        RoBDP_Qj_ready = 1'b1;
        RoBDP_Vj       = CDBRoB_RS_value;
      end else if (CDBRoB_LSB_en && (CDBRoB_LSB_RoB_index == DPRoB_Qj)) begin
        RoBDP_Qj_ready = 1'b1;
        RoBDP_Vj       = CDBRoB_LSB_value;
      end
    end
`endif
  end

  // Output drive; pulses are masked while the pipeline is frozen
  always_comb begin
    RoBDP_full          = full;
    RoBDP_tail          = tail_q;
    RoBRF_en            = rf_en_q && rdy_in;
    RoBRF_rd            = rf_rd_q;
    RoBRF_value         = rf_value_q;
    RoBRF_RoB_index     = rf_idx_q;
    RoBLSB_commit_en    = lsb_en_q && rdy_in;
    RoBLSB_commit_index = lsb_idx_q;
    RoB_flush_en        = flush_q && rdy_in;
    RoBIF_new_pc        = new_pc_q;
    RoB_halt            = halt_q;
  end

endmodule
